mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_wait_cnt.sv | 39 +++
 rtl/mc_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle controller: state encodings, opcodes,
// datapath mux / ALU codes and the bundled control-word type.
package mc_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_RWB    = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9;
  localparam logic [3:0] ST_ADDIEX = 4'd10;
  localparam logic [3:0] ST_ADDIWB = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_ce;
    logic       ir_ce;
    logic       mdr_ce;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       ill_op;
    logic       bus_err;
  } ctrl_t;

  // States that own the shared memory port and therefore wait on mem_ready.
  function automatic logic is_mem_state(input logic [3:0] st);
    return (st == ST_FETCH) || (st == ST_MEMRD) || (st == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// Memory wait counter: counts not-ready cycles in a memory state and flags
// when the count has reached the configured timeout.
module mc_wait_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q == W'(TIMEOUT));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-style control FSM with a bounded wait on the shared memory
// port; raises ill_op on unknown opcodes and bus_err on memory timeout.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_ce,
  output logic       ir_ce,
  output logic       mdr_ce,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       ill_op,
  output logic       bus_err,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  ctrl_t      ctl;
  logic       in_mem;
  logic       wait_expired;
  logic       timeout;
  logic       wait_clr;

  assign in_mem  = is_mem_state(state_q);
  // A ready memory completes the access even on the cycle the count expires.
  assign timeout = in_mem && !mem_ready && wait_expired;

  always_comb begin
    state_d = state_q;
    ctl     = '0;

    case (state_q)
      ST_FETCH: begin
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = SRC_B_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PC_SRC_ALU;
        if (mem_ready) begin
          ctl.ir_ce = 1'b1;
          ctl.pc_ce = 1'b1;
          state_d   = ST_DECODE;
        end
      end

      ST_DECODE: begin
        ctl.alu_src_b = SRC_B_BRANCH;
        ctl.alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDIEX;
          default: begin
            ctl.ill_op = 1'b1;
            state_d    = ST_FETCH;
          end
        endcase
      end

      ST_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_IMM;
        ctl.alu_op    = ALU_ADD;
        state_d       = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end

      ST_MEMRD: begin
        ctl.mem_req = 1'b1;
        ctl.i_or_d  = 1'b1;
        if (mem_ready) begin
          ctl.mdr_ce = 1'b1;
          state_d    = ST_MEMWB;
        end
      end

      ST_MEMWR: begin
        ctl.mem_req = 1'b1;
        ctl.mem_we  = 1'b1;
        ctl.i_or_d  = 1'b1;
        if (mem_ready) begin
          state_d = ST_FETCH;
        end
      end

      ST_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_REG;
        ctl.alu_op    = ALU_FUNCT;
        state_d       = ST_RWB;
      end

      ST_RWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        state_d       = ST_FETCH;
      end

      ST_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_REG;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_source = PC_SRC_ALUOUT;
        ctl.pc_ce     = zero;
        state_d       = ST_FETCH;
      end

      ST_JUMP: begin
        ctl.pc_source = PC_SRC_JUMP;
        ctl.pc_ce     = 1'b1;
        state_d       = ST_FETCH;
      end

      ST_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRC_B_IMM;
        ctl.alu_op    = ALU_ADD;
        state_d       = ST_ADDIWB;
      end

      ST_ADDIWB: begin
        ctl.reg_write = 1'b1;
        state_d       = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // Register enables in memory states only fire on ready, so none are live here.
    if (timeout) begin
      ctl.bus_err = 1'b1;
      state_d     = ST_FETCH;
    end
  end

  // Any transition (including FETCH re-entry after a timeout) starts a fresh wait.
  assign wait_clr = (state_d != state_q) || timeout;

  mc_wait_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .inc     (in_mem && !mem_ready),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: enables are gated by rst_n so reset silences them immediately, not at the next edge.
  assign pc_ce      = ctl.pc_ce     & rst_n;
  assign ir_ce      = ctl.ir_ce     & rst_n;
  assign mdr_ce     = ctl.mdr_ce    & rst_n;
  assign mem_we     = ctl.mem_we    & rst_n;
  assign reg_write  = ctl.reg_write & rst_n;
  assign ill_op     = ctl.ill_op    & rst_n;
  assign bus_err    = ctl.bus_err   & rst_n;
  assign mem_req    = ctl.mem_req;
  assign i_or_d     = ctl.i_or_d;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign pc_source  = ctl.pc_source;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction cycle plans are built from
// the instruction rules, then replayed against the DUT one cycle at a time.
module tb_mc_ctrl;

  localparam int unsigned TO = 4;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_ce, ir_ce, mdr_ce, mem_req, mem_we, i_or_d;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       ill_op, bus_err;
  logic [3:0] state;

  mc_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_ce      (pc_ce),
    .ir_ce      (ir_ce),
    .mdr_ce     (mdr_ce),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .i_or_d     (i_or_d),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .ill_op     (ill_op),
    .bus_err    (bus_err),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_ce;
    logic       ir_ce;
    logic       mdr_ce;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       ill_op;
    logic       bus_err;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    ctl_t       c;
  } step_t;

  ctl_t  obs;
  assign obs = {pc_ce, ir_ce, mdr_ce, mem_req, mem_we, i_or_d, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, ill_op, bus_err};

  step_t plan[$];
  int    n_pass = 0;
  int    n_chk  = 0;
  int    step_no = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s (step %0d): observed %0h expected %0h", tag, step_no, got, exp);
  endtask

  function automatic logic rbit();
    return ($urandom % 2) == 1;
  endfunction

  task automatic push(input logic [3:0] st, input logic [5:0] op, input logic z,
                      input logic rdy, input ctl_t c);
    step_t s;
    s.st = st; s.op = op; s.z = z; s.rdy = rdy; s.c = c;
    plan.push_back(s);
  endtask

  // A memory access of d not-ready cycles; beyond TO it times out after TO waits.
  task automatic access(input logic [3:0] st, input logic [5:0] op, input int d,
                        input ctl_t w, input ctl_t r, output bit ok);
    ctl_t t;
    if (d > int'(TO)) begin
      for (int i = 0; i < int'(TO); i++) push(st, op, rbit(), 1'b0, w);
      t = w;
      t.bus_err = 1'b1;
      push(st, op, rbit(), 1'b0, t);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < d; i++) push(st, op, rbit(), 1'b0, w);
      push(st, op, rbit(), 1'b1, r);
      ok = 1'b1;
    end
  endtask

  task automatic gen_instr(input logic [5:0] op, input logic z, input int df, input int dm);
    ctl_t c;
    ctl_t r;
    bit   ok;
    c = '0; c.mem_req = 1'b1; c.alu_src_b = 2'b01;
    r = c;  r.ir_ce = 1'b1;   r.pc_ce = 1'b1;
    access(S_FETCH, op, df, c, r, ok);
    if (!ok) return;
    c = '0; c.alu_src_b = 2'b11;
    if (!(op inside {LW, SW, RTY, BEQ, JMP, ADDI})) begin
      c.ill_op = 1'b1;
      push(S_DECODE, op, rbit(), rbit(), c);
      return;
    end
    push(S_DECODE, op, rbit(), rbit(), c);
    case (op)
      LW, SW: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        push(S_MEMADR, op, rbit(), rbit(), c);
        c = '0; c.mem_req = 1'b1; c.i_or_d = 1'b1;
        if (op == LW) begin
          r = c; r.mdr_ce = 1'b1;
          access(S_MEMRD, op, dm, c, r, ok);
          if (ok) begin
            c = '0; c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
            push(S_MEMWB, op, rbit(), rbit(), c);
          end
        end else begin
          c.mem_we = 1'b1;
          access(S_MEMWR, op, dm, c, c, ok);
        end
      end
      RTY: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b10;
        push(S_EXEC, op, rbit(), rbit(), c);
        c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1;
        push(S_RWB, op, rbit(), rbit(), c);
      end
      BEQ: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.pc_ce = z;
        push(S_BRANCH, op, z, rbit(), c);
      end
      JMP: begin
        c = '0; c.pc_source = 2'b10; c.pc_ce = 1'b1;
        push(S_JUMP, op, rbit(), rbit(), c);
      end
      default: begin
        c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        push(S_ADDIEX, op, rbit(), rbit(), c);
        c = '0; c.reg_write = 1'b1;
        push(S_ADDIWB, op, rbit(), rbit(), c);
      end
    endcase
  endtask

  // Called at a falling edge: apply inputs, check, then move to the next falling edge.
  task automatic run_steps(input int n);
    step_t s;
    for (int k = 0; k < n && plan.size() > 0; k++) begin
      s = plan.pop_front();
      opcode    = s.op;
      zero      = s.z;
      mem_ready = s.rdy;
      #1;
      chk("state", 32'(state), 32'(s.st));
      chk("ctrl", 32'(obs), 32'(s.c));
      step_no++;
      @(negedge clk);
    end
  endtask

  ctl_t en_mask;
  logic [5:0] rnd_op;
  logic [5:0] op_tab [6];

  initial begin
    op_tab = '{LW, SW, RTY, BEQ, JMP, ADDI};
    en_mask = '0;
    en_mask.pc_ce = 1'b1; en_mask.ir_ce = 1'b1; en_mask.mdr_ce = 1'b1;
    en_mask.reg_write = 1'b1; en_mask.mem_we = 1'b1;
    en_mask.ill_op = 1'b1; en_mask.bus_err = 1'b1;

    rst_n = 1'b1; opcode = LW; zero = 1'b0; mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'(S_FETCH));
    chk("reset_enables", 32'(obs & en_mask), 32'd0);
    repeat (2) @(negedge clk);
    chk("reset_hold_state", 32'(state), 32'(S_FETCH));
    chk("reset_hold_enables", 32'(obs & en_mask), 32'd0);
    rst_n = 1'b1;

    // lw with ready every access, then R-type with a 3-cycle fetch delay.
    gen_instr(LW, 1'b0, 0, 0);
    gen_instr(RTY, 1'b0, 3, 0);
    // beq not taken then taken, jump, addi.
    gen_instr(BEQ, 1'b0, 0, 0);
    gen_instr(BEQ, 1'b1, 1, 0);
    gen_instr(JMP, 1'b0, 0, 0);
    gen_instr(ADDI, 1'b0, 2, 0);
    // Illegal opcode, then a store that times out, then fetch boundary at exactly TO.
    gen_instr(6'b111111, 1'b0, 0, 0);
    gen_instr(SW, 1'b0, 0, 9);
    gen_instr(LW, 1'b0, int'(TO), int'(TO));
    gen_instr(RTY, 1'b0, int'(TO) + 1, 0);
    gen_instr(JMP, 1'b0, 0, 0);
    run_steps(plan.size());

    // Asynchronous reset in the middle of a load's memory read.
    gen_instr(LW, 1'b0, 0, 8);
    run_steps(3);
    plan.delete();
    opcode = LW; mem_ready = 1'b0;
    #1 chk("memrd_before_reset", 32'(state), 32'(S_MEMRD));
    @(negedge clk);
    #2 mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(state), 32'(S_FETCH));
    chk("async_reset_enables", 32'(obs & en_mask), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // A fetch that waits exactly TO cycles proves the wait count was cleared too.
    gen_instr(LW, 1'b0, int'(TO), 0);
    gen_instr(SW, 1'b0, 0, 1);
    run_steps(plan.size());

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) >= 6) rnd_op = 6'($urandom);
      else                           rnd_op = op_tab[$urandom_range(0, 5)];
      gen_instr(rnd_op, rbit(), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
    end
    gen_instr(LW, 1'b0, 0, 0);
    run_steps(plan.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
